// File: rtl/counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_bank : bank of independent up/down counters with per-      |
// |                channel limit, wrap/saturate, tc flags, readback    |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module counter_bank #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  parameter int  SATURATE = 0,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic                      wsel,
  input  logic [CW-1:0]             wch,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CW-1:0]             rch,
  output logic [WIDTH-1:0]          rdata,
  output logic [CHANNELS*WIDTH-1:0] data,
  output logic [CHANNELS-1:0]       tc
);

  localparam bit c_sat = (SATURATE != 0);

  logic [WIDTH-1:0] w_rsel;
  logic [WIDTH-1:0] r_rdata;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] r_limit;
      logic [WIDTH-1:0] w_next;
      logic             r_tc;
      logic             w_bound;
      logic             w_hit_top;
      logic             w_hit_bot;
      logic             w_count_wr;
      logic             w_limit_wr;

      assign w_count_wr = wr && !wsel && (wch == CW'(c));
      assign w_limit_wr = wr &&  wsel && (wch == CW'(c));
      // ">=" so a count left above a freshly lowered limit is still a bound
      assign w_hit_top  = (r_count >= r_limit);
      assign w_hit_bot  = (r_count == '0);

      always_comb begin
        w_next  = r_count;
        w_bound = 1'b0;
        if (en[c]) begin
          if (up[c]) begin
            if (w_hit_top) begin
              w_bound = 1'b1;
              w_next  = c_sat ? r_limit : '0;
            end else begin
              w_next  = r_count + 1'b1;
            end
          end else begin
            if (w_hit_bot) begin
              w_bound = 1'b1;
              w_next  = c_sat ? '0 : r_limit;
            end else begin
              w_next  = r_count - 1'b1;
            end
          end
        end
      end

      // Limit writes never block the step; the step above uses the old limit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_count <= '0;
          r_limit <= '1;
          r_tc    <= 1'b0;
        end else begin
          if (w_count_wr) begin
            r_count <= wdata;
            r_tc    <= 1'b0;
          end else begin
            r_count <= w_next;
            r_tc    <= w_bound;
          end
          if (w_limit_wr) begin
            r_limit <= wdata;
          end
        end
      end

      assign data[c*WIDTH +: WIDTH] = r_count;
      assign tc[c]                  = r_tc;
    end
  endgenerate

  // Unmatched rch values fall through to zero.
  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rch == CW'(i)) begin
        w_rsel = data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rsel;
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_counter_bank : scoreboard bench, wrap and saturate instances    |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_counter_bank;

  localparam int K_CNT   = 0;
  localparam int K_TC    = 1;
  localparam int K_RD    = 2;
  localparam int K_SCNT  = 3;
  localparam int K_STC   = 4;
  localparam int K_ALLD  = 5;
  localparam int K_ALLTC = 6;
  localparam int K_SALLD = 7;
  localparam int K_SALLT = 8;
  localparam int K_SRD   = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        wsel;
  logic [1:0]  wch;
  logic [7:0]  wdata;
  logic [3:0]  en;
  logic [3:0]  up;
  logic [1:0]  rch;
  logic [7:0]  rdata_w, rdata_s;
  logic [31:0] data_w, data_s;
  logic [3:0]  tc_w, tc_s;

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .wr(wr), .wsel(wsel), .wch(wch), .wdata(wdata),
    .en(en), .up(up), .rch(rch), .rdata(rdata_w), .data(data_w), .tc(tc_w)
  );

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .wr(wr), .wsel(wsel), .wch(wch), .wdata(wdata),
    .en(en), .up(up), .rch(rch), .rdata(rdata_s), .data(data_s), .tc(tc_s)
  );

  typedef struct {
    string       name;
    int          kind;
    int          ch;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] observe(input int kind, input int ch);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_CNT:   v = {24'h0, data_w[ch*8 +: 8]};
      K_TC:    v = {31'h0, tc_w[ch]};
      K_RD:    v = {24'h0, rdata_w};
      K_SCNT:  v = {24'h0, data_s[ch*8 +: 8]};
      K_STC:   v = {31'h0, tc_s[ch]};
      K_ALLD:  v = data_w;
      K_ALLTC: v = {28'h0, tc_w};
      K_SALLD: v = data_s;
      K_SALLT: v = {28'h0, tc_s};
      K_SRD:   v = {24'h0, rdata_s};
      default: v = 'x;
    endcase
    return v;
  endfunction

  function automatic void push(input string name, input int kind, input int ch,
                               input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.ch = ch; e.exp = v;
    sbq.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic sel, input int ch, input logic [7:0] v);
    wr = 1'b1; wsel = sel; wch = 2'(ch); wdata = v;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] got;
    reset = 1'b0; wr = 1'b0; wsel = 1'b0; wch = '0; wdata = '0;
    en = '0; up = '1; rch = '0;
    #3;
    push("rst_data",   K_ALLD,  0, 32'h0);
    push("rst_tc",     K_ALLTC, 0, 32'h0);
    push("rst_rdata",  K_RD,    0, 32'h0);
    push("rst_sdata",  K_SALLD, 0, 32'h0);
    push("rst_stc",    K_SALLT, 0, 32'h0);
    push("rst_srdata", K_SRD,   0, 32'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
      end
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_free_count();
    exp_t e;
    logic [31:0] got;
    en = 4'b0001; up = 4'b1111; rch = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      push("free_ch0",   K_CNT,   0, 32'(i));
      push("free_rdata", K_RD,    0, 32'(i - 1));
      push("free_tc",    K_ALLTC, 0, 32'h0);
      push("free_data",  K_ALLD,  0, 32'(i));
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
        end
      end
    end
    en = '0;
  endtask

  task automatic test_up_wrap();
    exp_t e;
    logic [31:0] got;
    logic [7:0] ec [4] = '{8'd4, 8'd5, 8'd0, 8'd1};
    logic       et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] sc [4] = '{8'd4, 8'd5, 8'd5, 8'd5};
    logic       st [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    en = '0;
    wr_reg(1'b1, 1, 8'd5);
    wr_reg(1'b0, 1, 8'd3);
    en = 4'b0010; up = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push("upwrap_cnt",  K_CNT,  1, 32'(ec[i]));
      push("upwrap_tc",   K_TC,   1, 32'(et[i]));
      push("upsat_cnt",   K_SCNT, 1, 32'(sc[i]));
      push("upsat_tc",    K_STC,  1, 32'(st[i]));
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
        end
      end
    end
    en = '0;
  endtask

  task automatic test_down_wrap();
    exp_t e;
    logic [31:0] got;
    logic [7:0] ec [3] = '{8'd0, 8'd9, 8'd8};
    logic       et [3] = '{1'b0, 1'b1, 1'b0};
    logic       st [3] = '{1'b0, 1'b1, 1'b1};
    en = '0;
    wr_reg(1'b1, 2, 8'd9);
    wr_reg(1'b0, 2, 8'd1);
    en = 4'b0100; up = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      push("dnwrap_cnt", K_CNT,  2, 32'(ec[i]));
      push("dnwrap_tc",  K_TC,   2, 32'(et[i]));
      push("dnsat_cnt",  K_SCNT, 2, 32'h0);
      push("dnsat_tc",   K_STC,  2, 32'(st[i]));
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
        end
      end
    end
    en = '0; up = 4'b1111;
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [31:0] got;
    logic [7:0] wc [4] = '{8'hFF, 8'h00, 8'h01, 8'h01};
    logic       wt [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       st [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    en = '0;
    wr_reg(1'b1, 0, 8'hFF);
    wr_reg(1'b0, 0, 8'hFE);
    en = 4'b0001; up = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) en = 4'b0000;
      push("sat_cnt",  K_SCNT, 0, 32'hFF);
      push("sat_tc",   K_STC,  0, 32'(st[i]));
      push("wrap_cnt", K_CNT,  0, 32'(wc[i]));
      push("wrap_tc",  K_TC,   0, 32'(wt[i]));
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
        end
      end
    end
    en = '0;
  endtask

  task automatic test_limit_zero();
    exp_t e;
    logic [31:0] got;
    en = '0;
    wr_reg(1'b1, 1, 8'd0);
    wr_reg(1'b0, 1, 8'd0);
    en = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      up = (i < 2) ? 4'b1111 : 4'b1101;
      if (i == 3) en = 4'b0000;
      push("lim0_cnt",  K_CNT,  1, 32'h0);
      push("lim0_tc",   K_TC,   1, (i < 3) ? 32'h1 : 32'h0);
      push("lim0_scnt", K_SCNT, 1, 32'h0);
      push("lim0_stc",  K_STC,  1, (i < 3) ? 32'h1 : 32'h0);
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
        end
      end
    end
    up = 4'b1111;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] got;
    logic [7:0] c3 [3] = '{8'h21, 8'h80, 8'h81};
    en = '0;
    wr_reg(1'b0, 0, 8'h10);
    wr_reg(1'b0, 3, 8'h20);
    en = 4'b1001; up = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        wr = 1'b1; wsel = 1'b0; wch = 2'd3; wdata = 8'h80;
      end else begin
        wr = 1'b0;
      end
      push("b2b_ch0", K_CNT, 0, 32'(8'h11 + i));
      push("b2b_ch3", K_CNT, 3, 32'(c3[i]));
      push("b2b_tc3", K_TC,  3, 32'h0);
      push("b2b_ch1", K_CNT, 1, 32'h0);
      push("b2b_ch2", K_CNT, 2, 32'h8);
      tick();
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
        if (got !== e.exp) begin
          n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
        end
      end
    end
    wr = 1'b0; en = '0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [31:0] got;
    en = '0;
    wr_reg(1'b1, 0, 8'h40);
    wr_reg(1'b1, 3, 8'h30);
    en = 4'b1111; up = 4'b1111;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    push("arst_data",   K_ALLD,  0, 32'h0);
    push("arst_tc",     K_ALLTC, 0, 32'h0);
    push("arst_rdata",  K_RD,    0, 32'h0);
    push("arst_sdata",  K_SALLD, 0, 32'h0);
    push("arst_srdata", K_SRD,   0, 32'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
      end
    end
    #2;
    en = '0;
    reset = 1'b1;
    wr_reg(1'b0, 0, 8'h50);
    en = 4'b0001;
    push("arst_lim0_step", K_CNT, 0, 32'h51);
    push("arst_lim0_tc",   K_TC,  0, 32'h0);
    tick();
    en = '0;
    wr_reg(1'b0, 3, 8'hFF);
    en = 4'b1000;
    push("arst_lim3_wrap", K_CNT, 3, 32'h0);
    push("arst_lim3_tc",   K_TC,  3, 32'h1);
    tick();
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); got = observe(e.kind, e.ch); n_cmp++;
      if (got !== e.exp) begin
        n_err++; $display("FAIL %s: got %0h required %0h", e.name, got, e.exp);
      end
    end
    en = '0;
  endtask

  initial begin
    test_reset();
    test_free_count();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_limit_zero();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
